sync_ptr: RTL and testbench
===========================

Name: sync_ptr

Overview:
- Parametrised pointer synchroniser for the async FIFO. Sits in the destination clock domain: read domain for the write pointer, write domain for the read pointer.
- Samples a Gray-coded pointer from the other domain through a configurable N-flop chain.
- Registers the binary equivalent of the synchronised pointer.
- Emits a change pulse and the pointer advance, so the full/empty and level logic needs no further arithmetic.

Parameters:
- WIDTH, 8, pointer width in bits, including the wrap bit; legal range 2..16.
- STAGES, 2, number of synchroniser flops; legal range 2..4. Elaboration error outside this range.

Ports:
- clk  in  1  destination-domain clock, rising edge.
- n_rst  in  1  synchronous active-low reset.
- ptr_gray_async  in  WIDTH  Gray-coded pointer from the source domain; asynchronous to clk.
- ptr_gray_sync  out  WIDTH  Gray pointer at the last synchroniser stage.
- ptr_bin  out  WIDTH  registered binary equivalent of ptr_gray_sync.
- ptr_chg  out  1  one-cycle pulse when ptr_bin updates to a new value.
- ptr_delta  out  WIDTH  (new ptr_bin − previous ptr_bin) mod 2^WIDTH while ptr_chg=1; 0 otherwise.
- err_clr  in  1  clears the sticky err flag.
- err  out  1  sticky Gray-violation flag (see Optional Feature).

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-low (clk, n_rst). Reset acts only on a rising clk edge with n_rst=0.
  - Every chain stage, ptr_gray_sync, ptr_bin, ptr_chg, ptr_delta and err clear to 0.
- Synchroniser chain:
  - stage[0] <= ptr_gray_async; stage[i] <= stage[i-1].
  - ptr_gray_sync = stage[STAGES-1], driven directly from that flop with no logic after it.
- Binary stage:
  - ptr_bin <= gray2bin(ptr_gray_sync), i.e. b[W-1]=g[W-1], b[i]=b[i+1]^g[i].
  - Input-to-ptr_bin latency is STAGES+1 edges; ptr_gray_sync latency is STAGES edges.
- Change detection (registered together with ptr_bin):
  - If gray2bin(ptr_gray_sync) != ptr_bin: ptr_chg <= 1 and ptr_delta <= gray2bin(ptr_gray_sync) − ptr_bin.
  - Otherwise: ptr_chg <= 0 and ptr_delta <= 0.
- Wrap-around:
  - Subtraction is modulo 2^WIDTH. 255→0 at WIDTH=8 gives ptr_delta=1.
  - A full lap returning to the same value is invisible, by design.
- Held input: ptr_chg is low for every cycle after the single update cycle.
- Reset mid-operation:
  - All state clears on the reset edge.
  - After release with a non-zero input, the chain refills. ptr_chg pulses once with ptr_delta equal to the input value; this is required behaviour, not a glitch.
- No state machine beyond the pipeline. There is no back-pressure or handshake; the consumer must accept ptr_chg every cycle.

Optional Feature:
- Macro: SYNC_PTR_GRAY_CHECK_EN.
- Defined:
  - A register holds the previous ptr_gray_sync.
  - If popcount(ptr_gray_sync ^ prev) > 1, err is set on the next edge.
  - err stays set until an edge with err_clr=1.
  - Set and clear in the same cycle: set wins.
  - The prev register and err clear on reset.
- Undefined: err is tied to 0, err_clr is ignored, and the prev register is absent.
- Ports are present in both builds.

Decomposition:
- Package sync_pkg:
  - functions gray2bin and bin2gray, parametrised by width via a max-width argument and mask;
  - constants SYNC_MIN_STAGES=2 and SYNC_MAX_STAGES=4.
- Sub-module sync_chain (WIDTH, STAGES):
  - pure flop chain with synchronous active-low reset;
  - reused by the FIFO's other pointer direction and by single-bit control synchronisers.
- Binary conversion, change detection and checker stay in sync_ptr.

Test Plan:
- Reset: n_rst=0 for 2 edges with ptr_gray_async=8'hFF → all outputs 0 and ptr_chg=0. Release with input 0 → ptr_chg stays 0.
- Latency (STAGES=2): drive ptr_gray_async 8'h00→8'h01 before edge 1:
  - ptr_gray_sync=8'h01 after edge 2;
  - ptr_bin=1, ptr_chg=1, ptr_delta=1 after edge 3;
  - ptr_chg=0 after edge 4.
  - Repeat with STAGES=4 → ptr_bin updates after edge 5.
- Wrap: step the Gray input through bin 254, 255, 0, one step every 3 cycles → ptr_bin 8'hFE, 8'hFF, 8'h00, each with a single ptr_chg and ptr_delta=1.
- Jump: input gray(3)=8'h02 → gray(7)=8'h04 → ptr_chg=1 and ptr_delta=4.
  - Check build: err=1 one edge after ptr_gray_sync changes.
  - Non-check build: err=0.
- Sticky err (check build):
  - after the jump, err stays 1 over 10 idle cycles;
  - err_clr=1 for one edge → err=0;
  - err_clr coincident with a new 2-bit jump → err remains 1.
- Reset mid-stream: with ptr_bin=8'h40 and input held at gray(0x40), pulse n_rst low for one edge:
  - outputs 0 on that edge;
  - after STAGES+1 edges, ptr_bin=8'h40 with ptr_chg=1 and ptr_delta=8'h40.

Source files
------------

// File: rtl/sync_pkg.sv
// Shared helpers for pointer/control synchronisers: Gray<->binary conversion
// over a fixed maximum width with a runtime width mask, plus stage limits.
package sync_pkg;

  localparam int SYNC_MIN_STAGES = 2;
  localparam int SYNC_MAX_STAGES = 4;
  localparam int SYNC_MAX_W      = 16;

  function automatic logic [SYNC_MAX_W-1:0] sync_mask(input int unsigned w);
    logic [SYNC_MAX_W:0] m;
    m = (17'd1 << w) - 17'd1;
    return m[SYNC_MAX_W-1:0];
  endfunction

  // b[i] is the XOR of all Gray bits at or above i
  function automatic logic [SYNC_MAX_W-1:0] gray2bin(input logic [SYNC_MAX_W-1:0] g,
                                                     input int unsigned w);
    logic [SYNC_MAX_W-1:0] gm, b;
    gm = g & sync_mask(w);
    for (int i = 0; i < SYNC_MAX_W; i++) b[i] = ^(gm >> i);
    return b;
  endfunction

  function automatic logic [SYNC_MAX_W-1:0] bin2gray(input logic [SYNC_MAX_W-1:0] b,
                                                     input int unsigned w);
    logic [SYNC_MAX_W-1:0] bm;
    bm = b & sync_mask(w);
    return bm ^ (bm >> 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain N-flop synchroniser chain with synchronous active-low reset; used for
// multi-bit Gray pointers and single-bit control signals alike.
module sync_chain
  import sync_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (STAGES < SYNC_MIN_STAGES || STAGES > SYNC_MAX_STAGES) begin : g_bad_stages
    $error("sync_chain: STAGES out of range");
  end

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/sync_ptr.sv
// Gray pointer synchroniser: flop chain, registered binary pointer, change
// pulse and advance. Optional Gray-violation checker: SYNC_PTR_GRAY_CHECK_EN.
module sync_ptr
  import sync_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] ptr_gray_async,
  output logic [WIDTH-1:0] ptr_gray_sync,
  output logic [WIDTH-1:0] ptr_bin,
  output logic             ptr_chg,
  output logic [WIDTH-1:0] ptr_delta,
  input  logic             err_clr,
  output logic             err
);

  if (WIDTH < 2 || WIDTH > SYNC_MAX_W) begin : g_bad_width
    $error("sync_ptr: WIDTH out of range");
  end
  if (STAGES < SYNC_MIN_STAGES || STAGES > SYNC_MAX_STAGES) begin : g_bad_stages
    $error("sync_ptr: STAGES out of range");
  end

  logic [WIDTH-1:0] bin_d, bin_q, delta_d, delta_q;
  logic             chg_d, chg_q;

  sync_chain #(.WIDTH(WIDTH), .STAGES(STAGES)) u_chain (
    .clk   (clk),
    .n_rst (n_rst),
    .d_i   (ptr_gray_async),
    .q_o   (ptr_gray_sync)
  );

  always_comb begin
    bin_d   = WIDTH'(gray2bin(SYNC_MAX_W'(ptr_gray_sync), WIDTH));
    chg_d   = (bin_d != bin_q);
    // modulo-2^WIDTH subtraction handles the wrap for free
    delta_d = chg_d ? (bin_d - bin_q) : '0;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      bin_q   <= '0;
      chg_q   <= 1'b0;
      delta_q <= '0;
    end else begin
      bin_q   <= bin_d;
      chg_q   <= chg_d;
      delta_q <= delta_d;
    end
  end

  assign ptr_bin   = bin_q;
  assign ptr_chg   = chg_q;
  assign ptr_delta = delta_q;

`ifdef SYNC_PTR_GRAY_CHECK_EN
  logic [WIDTH-1:0] prev_q;
  logic             err_d, err_q;

  // more than one Gray bit flipping between samples means a torn pointer
  always_comb begin
    err_d = err_q && !err_clr;
    if ($countones(ptr_gray_sync ^ prev_q) > 1) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      prev_q <= '0;
      err_q  <= 1'b0;
    end else begin
      prev_q <= ptr_gray_sync;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_sync_ptr.sv
// Scoreboard bench for sync_ptr at STAGES=2 and STAGES=4 driven in parallel;
// expectations come from a per-edge history of inputs and resets.
module tb_sync_ptr;

  localparam int MAXE = 2000;

  logic       clk = 1'b0;
  logic       n_rst, err_clr;
  logic [7:0] gin;

  logic [7:0] gs2, b2, d2, gs4, b4, d4;
  logic       chg2, err2, chg4, err4;

  always #5 clk = ~clk;

  sync_ptr #(.WIDTH(8), .STAGES(2)) dut2 (
    .clk(clk), .n_rst(n_rst), .ptr_gray_async(gin), .ptr_gray_sync(gs2),
    .ptr_bin(b2), .ptr_chg(chg2), .ptr_delta(d2), .err_clr(err_clr), .err(err2)
  );

  sync_ptr #(.WIDTH(8), .STAGES(4)) dut4 (
    .clk(clk), .n_rst(n_rst), .ptr_gray_async(gin), .ptr_gray_sync(gs4),
    .ptr_bin(b4), .ptr_chg(chg4), .ptr_delta(d4), .err_clr(err_clr), .err(err4)
  );

  typedef struct packed {
    logic [7:0] gs, bin, delta;
    logic       chg, err;
  } exp_t;

  exp_t q2[$], q4[$];

  logic [7:0] in_a [0:MAXE];
  bit         rst_a[0:MAXE];
  bit         clr_a[0:MAXE];
  bit         em2  [0:MAXE];
  bit         em4  [0:MAXE];
  int         n = 0;
  int         checks = 0, errors = 0;

  function automatic logic [7:0] g2b(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [7:0] b2g(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  // Value presented after edge e by something lat edges behind the input:
  // the sample taken at edge e-lat+1, or 0 if a reset edge intervened.
  function automatic logic [7:0] seen(input int e, input int lat);
    int k;
    k = e - lat + 1;
    if (k < 1) return 8'h00;
    for (int j = k; j <= e; j++) if (rst_a[j]) return 8'h00;
    return in_a[k];
  endfunction

  function automatic logic [7:0] gsm(input int e, input int s);
    return seen(e, s);
  endfunction

  function automatic logic [7:0] binm(input int e, input int s);
    return g2b(seen(e, s + 1));
  endfunction

  function automatic bit errm(input int e, input int s, input bit prev_err);
`ifdef SYNC_PTR_GRAY_CHECK_EN
    logic [7:0] prev;
    bit         set;
    if (rst_a[e]) return 1'b0;
    prev = (e - 1 < 1 || rst_a[e-1]) ? 8'h00 : gsm(e - 2, s);
    set  = $countones(gsm(e - 1, s) ^ prev) > 1;
    return set || (prev_err && !clr_a[e]);
`else
    return 1'b0 & prev_err & (e > s);
`endif
  endfunction

  function automatic exp_t expect_at(input int e, input int s, input bit ev);
    exp_t x;
    logic [7:0] pb;
    x.gs    = gsm(e, s);
    x.bin   = binm(e, s);
    pb      = binm(e - 1, s);
    x.chg   = !rst_a[e] && (x.bin != pb);
    x.delta = x.chg ? (x.bin - pb) : 8'h00;
    x.err   = ev;
    return x;
  endfunction

  task automatic step(input logic [7:0] g, input bit r, input bit c);
    gin     = g;
    n_rst   = ~r;
    err_clr = c;
    @(posedge clk);
    n++;
    if (n > MAXE) begin
      $display("FAIL history: edge %0d exceeds limit %0d", n, MAXE);
      $fatal(1, "history overflow");
    end
    in_a[n]  = g;
    rst_a[n] = r;
    clr_a[n] = c;
    em2[n]   = errm(n, 2, em2[n-1]);
    em4[n]   = errm(n, 4, em4[n-1]);
    q2.push_back(expect_at(n, 2, em2[n]));
    q4.push_back(expect_at(n, 4, em4[n]));
    #1;
  endtask

  task automatic hold(input logic [7:0] g, input int cyc);
    for (int i = 0; i < cyc; i++) step(g, 1'b0, 1'b0);
  endtask

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s edge %0d: got %0h, expected %0h", name, n, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q2.size() > 0) begin
        e = q2.pop_front();
        cmp("s2_gray_sync", gs2, e.gs);
        cmp("s2_bin", b2, e.bin);
        cmp("s2_chg", {7'd0, chg2}, {7'd0, e.chg});
        cmp("s2_delta", d2, e.delta);
        cmp("s2_err", {7'd0, err2}, {7'd0, e.err});
      end
      if (q4.size() > 0) begin
        e = q4.pop_front();
        cmp("s4_gray_sync", gs4, e.gs);
        cmp("s4_bin", b4, e.bin);
        cmp("s4_chg", {7'd0, chg4}, {7'd0, e.chg});
        cmp("s4_delta", d4, e.delta);
        cmp("s4_err", {7'd0, err4}, {7'd0, e.err});
      end
    end
  end

  initial begin
    logic [7:0] rb;
    int         r;
    gin = 8'hFF; n_rst = 1'b0; err_clr = 1'b0;
    em2[0] = 1'b0; em4[0] = 1'b0; rst_a[0] = 1'b1;

    // reset with all-ones input, then release with zero
    step(8'hFF, 1'b1, 1'b0);
    step(8'hFF, 1'b1, 1'b0);
    hold(8'h00, 4);
    // latency: single step 0 -> 1
    hold(8'h01, 7);
    // wrap through 254, 255, 0
    hold(b2g(8'd253), 7);
    hold(b2g(8'd254), 3);
    hold(b2g(8'd255), 3);
    hold(b2g(8'd0), 6);
    // multi-bit jump gray(3) -> gray(7), sticky err, then clear
    hold(b2g(8'd3), 7);
    hold(b2g(8'd7), 12);
    step(b2g(8'd7), 1'b0, 1'b1);
    hold(b2g(8'd7), 4);
    // clear held while a new 2-bit jump (8'h04 -> 8'h07) lands: set wins
    for (int i = 0; i < 7; i++) step(8'h07, 1'b0, 1'b1);
    hold(8'h07, 4);
    // reset mid-stream with input held at gray(0x40)
    hold(b2g(8'h40), 8);
    step(b2g(8'h40), 1'b1, 1'b0);
    hold(b2g(8'h40), 8);

    // randomized walk: mostly legal single steps, some jumps, clears, resets
    rb = 8'h40;
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(99);
      if (r < 40)      rb = rb;
      else if (r < 85) rb = rb + 8'd1;
      else             rb = 8'($urandom_range(255));
      step(b2g(rb), ($urandom_range(99) < 2), ($urandom_range(99) < 10));
    end
    hold(b2g(rb), 6);

    repeat (2) @(negedge clk);
    if (q2.size() != 0 || q4.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d expectations left, required 0", q2.size(), q4.size());
    end
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
